dcache_assoc: RTL and testbench
===============================

Name: dcache_assoc

Overview:
- Parametrised N-way set-associative data cache between the core load/store unit and a word-wide backing memory port.
- Successor to the flat preloaded cache: adds real tags, valid bits, per-set round-robin replacement, a line-refill FSM with a request/ack memory handshake, write-through stores, flush and misalignment detection.
- One outstanding core request at a time; the core stalls while op_ready is low.

Parameters:
WAYS, 4, associativity (power of 2, 1..8)
SETS, 64, sets (power of 2, >=2)
LINE_BYTES, 32, bytes per line (power of 2, >=4); OFF=log2(LINE_BYTES), IDX=log2(SETS), TAG=32-IDX-OFF

Ports:
ip_clk  in  1  clock
ip_rst  in  1  reset, asynchronous, active-high
ip_req  in  1  core request, sampled when op_ready=1
ip_we  in  1  1=store, 0=load
ip_addr  in  32  byte address
ip_wdata  in  32  store data, LSB-aligned
ip_size  in  2  00 byte, 01 half, 1x word
ip_load_sign_ctrl  in  1  0=sign-extend, 1=zero-extend
ip_flush  in  1  invalidate all lines (IDLE only)
op_ready  out  1  high only in IDLE
op_ack  out  1  one-cycle completion pulse
op_rdata  out  32  extended load data, valid with op_ack
op_misalign  out  1  with op_ack: access aborted
op_mem_req  out  1  memory request, held until ip_mem_ack
op_mem_we  out  1  memory write
op_mem_addr  out  32  word address (bits[1:0]=0)
op_mem_wdata  out  32  lane-shifted store data
op_mem_be  out  4  byte enables
ip_mem_ack  in  1  memory accepts/returns word this cycle
ip_mem_rdata  in  32  read word, valid with ip_mem_ack

Behaviour:
- Reset: FSM=IDLE, all valid bits=0, all round-robin pointers=0, op_ack/op_misalign/op_mem_req/op_mem_we=0, op_rdata/op_mem_addr/op_mem_wdata=0, op_mem_be=0, op_ready=1. Data/tag arrays are not cleared. Reset mid-refill abandons it: op_mem_req drops asynchronously and the line is never validated.
- Address split: offset=addr[OFF-1:0], index=addr[OFF+IDX-1:OFF], tag=addr[31:OFF+IDX].
- States: IDLE, LOOKUP, REFILL, WRITE.
- IDLE: ip_flush=1 clears all valid bits and pointers in one cycle. flush has priority; a simultaneous ip_req is ignored. Otherwise, ip_req=1 registers addr/we/wdata/size/sign and moves to LOOKUP.
- LOOKUP: compare the tag across all ways, hit = valid & tag match.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): op_ack=1, op_misalign=1, op_rdata=0, no memory traffic or array change, -> IDLE.
  - Load hit: op_ack=1 with op_rdata this cycle, -> IDLE. Hit latency 2 cycles from acceptance edge.
  - Load miss: select victim = lowest-index invalid way, else the set's round-robin pointer, -> REFILL.
  - Store (hit or miss): on hit, merge enabled bytes into the cached line; on miss, no allocate. -> WRITE.
- REFILL: fetch LINE_BYTES/4 words in ascending order from the line base.
  - op_mem_req=1, op_mem_we=0, op_mem_be=4'hF. Each word is written into the victim way on ip_mem_ack, then the address advances.
  - After the last ack: set tag and valid; if the victim came from the pointer, increment the pointer (wraps modulo WAYS); -> LOOKUP, which now hits.
- WRITE: op_mem_req=1, op_mem_we=1, op_mem_addr={addr[31:2],2'b00}.
  - Byte: be=1<<addr[1:0], wdata replicated to the lane.
  - Half: be=3<<addr[1:0].
  - Word: be=4'hF.
  - Hold until ip_mem_ack, then op_ack=1 that cycle, -> IDLE.
- Load extract: pick the lane from word addr[OFF-1:2] and bytes addr[1:0].
  - Byte/half: extend from bit 7/15 when sign_ctrl=0, zero-fill when sign_ctrl=1.
  - Word: returned unchanged.
- op_mem_* outputs are stable while op_mem_req=1 and ip_mem_ack=0. op_mem_req=0 in IDLE/LOOKUP.
- ip_mem_ack while op_mem_req=0 is ignored.
- ip_req/ip_flush outside IDLE are ignored.

Test Plan:
- Reset, load word 0x0000_1000 -> REFILL issues 8 reads at 0x1000..0x101C (mem returns addr value), op_ack with op_rdata=0x0000_1000; repeat load -> op_ack 2 cycles after acceptance, no op_mem_req.
- Memory word 0x1004=0x0000_80F0; load byte 0x1004 sign_ctrl=0 -> 0xFFFF_FFF0; sign_ctrl=1 -> 0x0000_00F0; load half 0x1004 sign_ctrl=0 -> 0xFFFF_80F0.
- Store byte 0xAB to 0x1006 (hit) -> op_mem_be=4'b0100, op_mem_wdata[23:16]=0xAB, ack delayed 3 cycles by memory; subsequent load word 0x1004 hits -> 0x00AB_80F0. Store to uncached 0x9000 -> memory write only, next load 0x9000 misses.
- WAYS=4: fill one set with 5 distinct tags -> 5th refill evicts way 0; 6th evicts way 1; reloading the first tag misses.
- Half load at 0x1001 and word store at 0x1002 -> op_ack=1, op_misalign=1, op_mem_req never asserted.
- ip_rst asserted after 3 refill acks -> op_mem_req low immediately; after release, load the same address -> full 8-word refill. ip_flush with ip_req in IDLE -> request dropped, next load misses.

Source files
------------

// File: rtl/dcache_assoc.sv
// N-way set-associative data cache: tag/valid lookup, round-robin replacement,
// line refill over a request/ack word port, write-through stores with no write-allocate.
module dcache_assoc #(
  parameter int WAYS       = 4,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 32
) (
  input  logic        ip_clk,
  input  logic        ip_rst,
  input  logic        ip_req,
  input  logic        ip_we,
  input  logic [31:0] ip_addr,
  input  logic [31:0] ip_wdata,
  input  logic [1:0]  ip_size,
  input  logic        ip_load_sign_ctrl,
  input  logic        ip_flush,
  output logic        op_ready,
  output logic        op_ack,
  output logic [31:0] op_rdata,
  output logic        op_misalign,
  output logic        op_mem_req,
  output logic        op_mem_we,
  output logic [31:0] op_mem_addr,
  output logic [31:0] op_mem_wdata,
  output logic [3:0]  op_mem_be,
  input  logic        ip_mem_ack,
  input  logic [31:0] ip_mem_rdata,
  output logic [1:0]  op_dbg_state
);
  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int IDX   = $clog2(SETS);
  localparam int TAGW  = 32 - IDX - OFF;
  localparam int WORDS = LINE_BYTES / 4;
  localparam int WB    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE} state_t;

  // Memory handshake: op_mem_* are held stable while op_mem_req=1; a word
  // transfers on the clock edge where op_mem_req and ip_mem_ack are both high.
  state_t           r_state;
  logic             r_ready, r_ack, r_misalign;
  logic [31:0]      r_rdata;
  logic             r_mem_req, r_mem_we;
  logic [31:0]      r_mem_addr, r_mem_wdata;
  logic [3:0]       r_mem_be;
  logic [31:0]      r_addr, r_wdata;
  logic             r_we, r_sign;
  logic [1:0]       r_size;
  logic [WB-1:0]    r_cnt;
  logic [WW-1:0]    r_victim;
  logic             r_victim_ptr;

  logic [31:0]      r_data  [WAYS][SETS][WORDS];
  logic [TAGW-1:0]  r_tag   [WAYS][SETS];
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WW-1:0]    r_ptr   [SETS];

  logic [TAGW-1:0]  w_tag;
  logic [IDX-1:0]   w_idx;
  logic [WB-1:0]    w_wsel;
  logic             w_hit, w_from_ptr, w_misalign, w_last;
  logic [WW-1:0]    w_hit_way, w_victim;
  logic [31:0]      w_word, w_lane, w_load, w_st_data;
  logic [3:0]       w_st_be;

  assign w_tag  = r_addr[31:OFF+IDX];
  assign w_idx  = r_addr[OFF+IDX-1:OFF];
  assign w_wsel = WB'((r_addr >> 2) & 32'(WORDS - 1));
  assign w_last = (r_cnt == WB'(WORDS - 1));
  assign w_misalign = ((r_size == 2'b01) && r_addr[0]) ||
                      (r_size[1] && (r_addr[1:0] != 2'b00));

  always_comb begin
    w_hit = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit = 1'b1;
        w_hit_way = WW'(w);
      end
    end
  end

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    w_victim = r_ptr[w_idx];
    w_from_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_victim = WW'(w);
        w_from_ptr = 1'b0;
      end
    end
  end

  assign w_word = r_data[w_hit_way][w_idx][w_wsel];
  assign w_lane = w_word >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_word;
    case (r_size)
      2'b00:   w_load = r_sign ? {24'b0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load = r_sign ? {16'b0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    w_st_be = 4'hF;
    w_st_data = r_wdata;
    case (r_size)
      2'b00: begin
        w_st_be = 4'b0001 << r_addr[1:0];
        w_st_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_st_be = r_addr[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Data and tag arrays carry no reset; validity lives in r_valid.
  always_ff @(posedge ip_clk) begin
    if (r_state == S_REFILL && ip_mem_ack) begin
      r_data[r_victim][w_idx][r_cnt] <= ip_mem_rdata;
      if (w_last) r_tag[r_victim][w_idx] <= w_tag;
    end
    if (r_state == S_LOOKUP && r_we && w_hit && !w_misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (w_st_be[b]) r_data[w_hit_way][w_idx][w_wsel][8*b +: 8] <= w_st_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_ack <= 1'b0;
      r_misalign <= 1'b0;
      r_rdata <= '0;
      r_mem_req <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wdata <= '0;
      r_mem_be <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_we <= 1'b0;
      r_sign <= 1'b0;
      r_size <= '0;
      r_cnt <= '0;
      r_victim <= '0;
      r_victim_ptr <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s] <= '0;
      end
    end else begin
      r_ack <= 1'b0;
      r_misalign <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (ip_flush) begin
            for (int s = 0; s < SETS; s++) begin
              r_valid[s] <= '0;
              r_ptr[s] <= '0;
            end
          end else if (ip_req) begin
            r_addr <= ip_addr;
            r_we <= ip_we;
            r_wdata <= ip_wdata;
            r_size <= ip_size;
            r_sign <= ip_load_sign_ctrl;
            r_ready <= 1'b0;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_misalign) begin
            r_ack <= 1'b1;
            r_misalign <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else if (!r_we && w_hit) begin
            r_ack <= 1'b1;
            r_rdata <= w_load;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else if (!r_we) begin
            r_victim <= w_victim;
            r_victim_ptr <= w_from_ptr;
            r_cnt <= '0;
            r_mem_req <= 1'b1;
            r_mem_we <= 1'b0;
            r_mem_be <= 4'hF;
            r_mem_addr <= {r_addr[31:OFF], {OFF{1'b0}}};
            r_state <= S_REFILL;
          end else begin
            r_mem_req <= 1'b1;
            r_mem_we <= 1'b1;
            r_mem_be <= w_st_be;
            r_mem_wdata <= w_st_data;
            r_mem_addr <= {r_addr[31:2], 2'b00};
            r_state <= S_WRITE;
          end
        end
        S_REFILL: begin
          if (ip_mem_ack) begin
            r_cnt <= r_cnt + WB'(1);
            r_mem_addr <= r_mem_addr + 32'd4;
            if (w_last) begin
              r_mem_req <= 1'b0;
              r_mem_be <= '0;
              r_valid[w_idx][r_victim] <= 1'b1;
              if (r_victim_ptr) begin
                r_ptr[w_idx] <= (r_ptr[w_idx] == WW'(WAYS - 1)) ? '0 : r_ptr[w_idx] + WW'(1);
              end
              r_state <= S_LOOKUP;
            end
          end
        end
        S_WRITE: begin
          if (ip_mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we <= 1'b0;
            r_mem_be <= '0;
            r_ack <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_ready     = r_ready;
  assign op_ack       = r_ack;
  assign op_rdata     = r_rdata;
  assign op_misalign  = r_misalign;
  assign op_mem_req   = r_mem_req;
  assign op_mem_we    = r_mem_we;
  assign op_mem_addr  = r_mem_addr;
  assign op_mem_wdata = r_mem_wdata;
  assign op_mem_be    = r_mem_be;
  assign op_dbg_state = r_state;

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: word-port memory model, hit/miss, extension,
// write-through, replacement order, misalignment, reset mid-refill and flush.
module tb_dcache_assoc;
  logic        ip_clk = 1'b0;
  logic        ip_rst;
  logic        ip_req = 1'b0;
  logic        ip_we = 1'b0;
  logic [31:0] ip_addr = '0;
  logic [31:0] ip_wdata = '0;
  logic [1:0]  ip_size = '0;
  logic        ip_load_sign_ctrl = 1'b0;
  logic        ip_flush = 1'b0;
  logic        op_ready, op_ack, op_misalign;
  logic [31:0] op_rdata;
  logic        op_mem_req, op_mem_we;
  logic [31:0] op_mem_addr, op_mem_wdata;
  logic [3:0]  op_mem_be;
  logic        ip_mem_ack = 1'b0;
  logic [31:0] ip_mem_rdata = '0;
  logic [1:0]  op_dbg_state;

  int n_total = 0;
  int n_bad = 0;

  dcache_assoc #(.WAYS(4), .SETS(64), .LINE_BYTES(32)) dut (
    .ip_clk(ip_clk), .ip_rst(ip_rst), .ip_req(ip_req), .ip_we(ip_we),
    .ip_addr(ip_addr), .ip_wdata(ip_wdata), .ip_size(ip_size),
    .ip_load_sign_ctrl(ip_load_sign_ctrl), .ip_flush(ip_flush),
    .op_ready(op_ready), .op_ack(op_ack), .op_rdata(op_rdata),
    .op_misalign(op_misalign), .op_mem_req(op_mem_req), .op_mem_we(op_mem_we),
    .op_mem_addr(op_mem_addr), .op_mem_wdata(op_mem_wdata), .op_mem_be(op_mem_be),
    .ip_mem_ack(ip_mem_ack), .ip_mem_rdata(ip_mem_rdata), .op_dbg_state(op_dbg_state)
  );

  // clock / reset
  always #5 ip_clk = ~ip_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // backing memory model: unwritten words read back as their own address
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q [$];
  logic [31:0] rd_addr_q [$];
  int          mem_delay = 0;
  int          wcnt = 0;
  int          wr_cnt = 0;
  int          ack_cnt = 0;
  logic        req_seen = 1'b0;
  logic [31:0] last_wr_addr = '0, last_wr_data = '0;
  logic [3:0]  last_wr_be = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a;
  endfunction

  initial begin
    logic [31:0] v;
    forever begin
      @(negedge ip_clk);
      if (ip_rst) begin
        ip_mem_ack = 1'b0;
        wcnt = 0;
      end else if (ip_mem_ack) begin
        ip_mem_ack = 1'b0;
        wcnt = 0;
      end else if (op_mem_req) begin
        if (wcnt >= mem_delay) begin
          ip_mem_ack = 1'b1;
          if (op_mem_we) begin
            v = mem_rd(op_mem_addr);
            for (int b = 0; b < 4; b++)
              if (op_mem_be[b]) v[8*b +: 8] = op_mem_wdata[8*b +: 8];
            mem[op_mem_addr] = v;
            wr_cnt++;
            last_wr_addr = op_mem_addr;
            last_wr_data = op_mem_wdata;
            last_wr_be = op_mem_be;
          end else begin
            ip_mem_rdata = mem_rd(op_mem_addr);
            rd_addr_q.push_back(op_mem_addr);
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  always @(posedge ip_clk) begin
    if (op_mem_req) req_seen = 1'b1;
    if (op_mem_req && ip_mem_ack && !op_mem_we) ack_cnt++;
  end

  // driver: one core access, returns data/misalign and negedges until op_ack
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz, input logic sgn,
                           output logic [31:0] rd, output logic mis, output int cyc);
    @(negedge ip_clk);
    req_seen = 1'b0;
    rd_addr_q.delete();
    wr_cnt = 0;
    ip_req = 1'b1; ip_we = we; ip_addr = addr; ip_wdata = wd;
    ip_size = sz; ip_load_sign_ctrl = sgn;
    @(posedge ip_clk);
    cyc = 0; rd = '0; mis = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge ip_clk);
      if (k == 0) ip_req = 1'b0;
      cyc++;
      if (op_ack) begin
        rd = op_rdata;
        mis = op_misalign;
        break;
      end
    end
    if (!op_ack) chk("ack_timeout", {31'b0, op_ack}, 32'd1);
  endtask

  // load that must miss (8-word refill from line base) and return exp
  task automatic load_miss(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic mis; int cyc;
    logic [31:0] base;
    base = {addr[31:5], 5'b0};
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(base + 32'(4 * i));
    do_access(1'b0, addr, '0, 2'b10, 1'b0, rd, mis, cyc);
    chk({tag, "_rd"}, rd, exp);
    chk({tag, "_nreads"}, 32'(rd_addr_q.size()), 32'd8);
    while (exp_q.size() > 0 && rd_addr_q.size() > 0) begin
      chk({tag, "_raddr"}, rd_addr_q.pop_front(), exp_q.pop_front());
    end
  endtask

  task automatic load_hit(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] exp);
    logic [31:0] rd; logic mis; int cyc;
    do_access(1'b0, addr, '0, sz, sgn, rd, mis, cyc);
    chk({tag, "_rd"}, rd, exp);
    chk({tag, "_memreq"}, {31'b0, req_seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd; logic mis; int cyc;
    mem[32'h1004] = 32'h0000_80F0;
    ip_rst = 1'b1;
    repeat (3) @(negedge ip_clk);
    chk("rst_ready", {31'b0, op_ready}, 32'd1);
    chk("rst_ack", {31'b0, op_ack}, 32'd0);
    chk("rst_memreq", {31'b0, op_mem_req}, 32'd0);
    chk("rst_membe", {28'b0, op_mem_be}, 32'd0);
    chk("rst_rdata", op_rdata, 32'd0);
    chk("rst_memaddr", op_mem_addr, 32'd0);
    chk("rst_state", {30'b0, op_dbg_state}, 32'd0);
    ip_rst = 1'b0;

    // cold miss then hit with 2-cycle latency
    load_miss("first", 32'h0000_1000, 32'h0000_1000);
    do_access(1'b0, 32'h0000_1000, '0, 2'b10, 1'b0, rd, mis, cyc);
    chk("hit_rd", rd, 32'h0000_1000);
    chk("hit_lat", 32'(cyc), 32'd2);
    chk("hit_memreq", {31'b0, req_seen}, 32'd0);

    // extension
    load_hit("lb_s", 32'h0000_1004, 2'b00, 1'b0, 32'hFFFF_FFF0);
    load_hit("lb_z", 32'h0000_1004, 2'b00, 1'b1, 32'h0000_00F0);
    load_hit("lh_s", 32'h0000_1004, 2'b01, 1'b0, 32'hFFFF_80F0);
    load_hit("lh_z", 32'h0000_1004, 2'b01, 1'b1, 32'h0000_80F0);
    load_hit("lb1_s", 32'h0000_1005, 2'b00, 1'b0, 32'hFFFF_FF80);

    // store byte hit, memory adds 3 wait cycles
    mem_delay = 3;
    do_access(1'b1, 32'h0000_1006, 32'h0000_00AB, 2'b00, 1'b0, rd, mis, cyc);
    mem_delay = 0;
    chk("sb_lat", 32'(cyc), 32'd6);
    chk("sb_be", {28'b0, last_wr_be}, 32'h4);
    chk("sb_lane", {24'b0, last_wr_data[23:16]}, 32'hAB);
    chk("sb_addr", last_wr_addr, 32'h0000_1004);
    chk("sb_nwr", 32'(wr_cnt), 32'd1);
    load_hit("sb_merge", 32'h0000_1004, 2'b10, 1'b0, 32'h00AB_80F0);

    // store miss: write-through only, no allocate
    do_access(1'b1, 32'h0000_9000, 32'h1234_5678, 2'b10, 1'b0, rd, mis, cyc);
    chk("sw_miss_be", {28'b0, last_wr_be}, 32'hF);
    chk("sw_miss_nrd", 32'(rd_addr_q.size()), 32'd0);
    chk("sw_miss_nwr", 32'(wr_cnt), 32'd1);
    load_miss("sw_noalloc", 32'h0000_9000, 32'h1234_5678);

    // replacement in set 5: four fills, then pointer-driven evictions
    for (int t = 0; t < 4; t++)
      load_miss("fill", 32'h0000_40A0 + 32'(t * 32'h800), 32'h0000_40A0 + 32'(t * 32'h800));
    load_miss("fill5", 32'h0000_60A0, 32'h0000_60A0);
    load_hit("keep1", 32'h0000_48A0, 2'b10, 1'b0, 32'h0000_48A0);
    load_hit("keep3", 32'h0000_58A0, 2'b10, 1'b0, 32'h0000_58A0);
    load_miss("fill6", 32'h0000_68A0, 32'h0000_68A0);
    load_hit("keep2", 32'h0000_50A0, 2'b10, 1'b0, 32'h0000_50A0);
    load_miss("evicted0", 32'h0000_40A0, 32'h0000_40A0);
    load_hit("keep4", 32'h0000_60A0, 2'b10, 1'b0, 32'h0000_60A0);
    load_hit("keep5", 32'h0000_68A0, 2'b10, 1'b0, 32'h0000_68A0);
    load_miss("evicted2", 32'h0000_50A0, 32'h0000_50A0);

    // misalignment aborts with no memory traffic
    do_access(1'b0, 32'h0000_1001, '0, 2'b01, 1'b0, rd, mis, cyc);
    chk("mis_lh", {31'b0, mis}, 32'd1);
    chk("mis_lh_rd", rd, 32'd0);
    chk("mis_lh_memreq", {31'b0, req_seen}, 32'd0);
    do_access(1'b1, 32'h0000_1002, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, mis, cyc);
    chk("mis_sw", {31'b0, mis}, 32'd1);
    chk("mis_sw_memreq", {31'b0, req_seen}, 32'd0);
    load_hit("mis_nochange", 32'h0000_1000, 2'b10, 1'b0, 32'h0000_1000);

    // reset after 3 refill acks
    @(negedge ip_clk);
    ack_cnt = 0;
    ip_req = 1'b1; ip_we = 1'b0; ip_addr = 32'h0000_3000; ip_size = 2'b10;
    @(posedge ip_clk);
    @(negedge ip_clk);
    ip_req = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge ip_clk);
      #1;
      if (ack_cnt >= 3) break;
    end
    chk("rst_mid_acks", 32'(ack_cnt), 32'd3);
    ip_rst = 1'b1;
    #1;
    chk("rst_mid_memreq", {31'b0, op_mem_req}, 32'd0);
    chk("rst_mid_ready", {31'b0, op_ready}, 32'd1);
    repeat (2) @(negedge ip_clk);
    ip_rst = 1'b0;
    load_miss("rst_refill", 32'h0000_3000, 32'h0000_3000);

    // flush beats a simultaneous request
    @(negedge ip_clk);
    ip_flush = 1'b1; ip_req = 1'b1; ip_we = 1'b0; ip_addr = 32'h0000_3000; ip_size = 2'b10;
    @(posedge ip_clk);
    @(negedge ip_clk);
    ip_flush = 1'b0; ip_req = 1'b0;
    chk("flush_ready", {31'b0, op_ready}, 32'd1);
    chk("flush_state", {30'b0, op_dbg_state}, 32'd0);
    @(negedge ip_clk);
    chk("flush_noack", {31'b0, op_ack}, 32'd0);
    load_miss("flush_miss", 32'h0000_3000, 32'h0000_3000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
